tile_seq_ctrl: RTL

Job-level controller for the matrix row buffer. It accepts a tile-job command and launches one buffer read/send cycle per tile, but only when the downstream array is ready. It relocates the buffer's local row addresses into global memory addresses and tracks the buffer's skewed output bursts to detect tile and job completion, with a watchdog and a burst-length checker.

---
 rtl/tile_seq_pkg.sv | 22 ++
 rtl/tile_addr_gen.sv | 41 ++++
 rtl/tile_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tile_seq_pkg.sv
// Shared types and derived constants for the tile job sequencer.
package tile_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_VALID = 2'd2,
        STREAM     = 2'd3
    } seq_state_e;

    // Memory read latency inside the row buffer; relocation must add none.
    localparam int MEM_LATENCY = 2;

    function automatic int calc_latency(input int mem_depth, input int opn);
        return mem_depth + opn - 1;
    endfunction

    function automatic int calc_send_times(input int ipn, input int opn);
        return ipn - opn + 1;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile base accumulator and per-port relocation of buffer-local row addresses.
module tile_addr_gen
    import tile_seq_pkg::*;
#(
    parameter int IPN        = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BASE_WIDTH = 12,
    parameter int ROW_PITCH  = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      load,
    input  logic [BASE_WIDTH-1:0]     load_base,
    input  logic                      advance,
    input  logic [BASE_WIDTH-1:0]     stride,
    input  logic [IPN*ADDR_WIDTH-1:0] buf_addr_i,
    output logic [IPN*BASE_WIDTH-1:0] mem_addr_o
);

    logic [BASE_WIDTH-1:0] tile_base;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tile_base <= '0;
        end else if (load) begin
            tile_base <= load_base;
        end else if (advance) begin
            tile_base <= tile_base + stride;
        end
    end

    // Purely combinational so the buffer's memory read timing is untouched.
    always_comb begin
        for (int i = 0; i < IPN; i++) begin
            mem_addr_o[i*BASE_WIDTH +: BASE_WIDTH] = tile_base
                + BASE_WIDTH'(i * ROW_PITCH)
                + BASE_WIDTH'(buf_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

endmodule

// File: rtl/tile_seq_ctrl.sv
// Job-level controller: launches one buffer read/send cycle per tile and
// tracks the skewed output bursts for tile/job completion and errors.
//
// state      | meaning
// IDLE       | waiting for a job command (cmd_ready=1)
// ARM        | tile pending, waiting for array_ready to pulse buf_en
// WAIT_VALID | launched, watchdog running until first buf_data_valid
// STREAM     | counting output bursts until the tile completes
module tile_seq_ctrl
    import tile_seq_pkg::*;
#(
    parameter int MEM_DEPTH           = 8,
    parameter int INPUT_PARALLEL_NUM  = 8,
    parameter int OUTPUT_PARALLEL_NUM = 3,
    parameter int ADDR_WIDTH          = $clog2(MEM_DEPTH),
    parameter int BASE_WIDTH          = 12,
    parameter int TILE_CNT_WIDTH      = 8,
    parameter int ROW_PITCH           = MEM_DEPTH,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [BASE_WIDTH-1:0]                    cmd_base,
    input  logic [BASE_WIDTH-1:0]                    cmd_stride,
    input  logic [TILE_CNT_WIDTH-1:0]                cmd_num_tiles,
    input  logic                                     array_ready,
    output logic                                     buf_en,
    input  logic [INPUT_PARALLEL_NUM*ADDR_WIDTH-1:0] buf_addr_i,
    input  logic                                     buf_data_valid,
    output logic [INPUT_PARALLEL_NUM*BASE_WIDTH-1:0] mem_addr_o,
    output logic [TILE_CNT_WIDTH-1:0]                tile_idx,
    output logic                                     busy,
    output logic                                     tile_done,
    output logic                                     job_done,
    output logic                                     err_timeout,
    output logic                                     err_burst
);

    localparam int LATENCY    = calc_latency(MEM_DEPTH, OUTPUT_PARALLEL_NUM);
    localparam int SEND_TIMES = calc_send_times(INPUT_PARALLEL_NUM, OUTPUT_PARALLEL_NUM);
    localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BC_W       = $clog2(SEND_TIMES + 1);
    localparam int RL_W       = $clog2(LATENCY + 2);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(LATENCY + 1);

    seq_state_e state_q, state_d;

    logic [BASE_WIDTH-1:0]     stride_q;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_q;
    logic [TILE_CNT_WIDTH-1:0] tile_idx_q;
    logic [WD_W-1:0]           wd_q;
    logic [BC_W-1:0]           burst_q;
    logic [RL_W-1:0]           run_q;
    logic                      valid_q;
    logic                      err_timeout_q;
    logic                      err_burst_q;
    logic                      zero_done_q;

    logic accept, fall, last_burst, last_tile;
    logic timeout, advance, job_end;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_en     = 1'b0;
        tile_done  = 1'b0;
        job_end    = 1'b0;
        timeout    = 1'b0;
        advance    = 1'b0;
        accept     = cmd_valid && (state_q == IDLE);
        fall       = valid_q && !buf_data_valid;
        last_burst = (burst_q == BC_W'(SEND_TIMES - 1));
        last_tile  = (tile_idx_q == num_tiles_q - TILE_CNT_WIDTH'(1));
        case (state_q)
            IDLE: begin
                if (accept && (cmd_num_tiles != '0)) state_d = ARM;
            end
            ARM: begin
                if (array_ready) begin
                    buf_en  = 1'b1;
                    state_d = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (buf_data_valid) begin
                    state_d = STREAM;
                end else if (wd_q == '0) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (fall && last_burst) begin
                    tile_done = 1'b1;
                    if (last_tile) begin
                        job_end = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stride_q      <= '0;
            num_tiles_q   <= '0;
            tile_idx_q    <= '0;
            err_timeout_q <= 1'b0;
            err_burst_q   <= 1'b0;
            zero_done_q   <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            valid_q     <= buf_data_valid;
            zero_done_q <= accept && (cmd_num_tiles == '0);
            if (accept) begin
                stride_q      <= cmd_stride;
                num_tiles_q   <= cmd_num_tiles;
                tile_idx_q    <= '0;
                err_timeout_q <= 1'b0;
                err_burst_q   <= 1'b0;
            end else begin
                if (advance) tile_idx_q <= tile_idx_q + TILE_CNT_WIDTH'(1);
                if (timeout) err_timeout_q <= 1'b1;
                if ((state_q == STREAM) && fall && (run_q != RL_W'(LATENCY)))
                    err_burst_q <= 1'b1;
            end
        end
    end

    // Watchdog down-counter: loaded at launch, expires at terminal count zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_q <= '0;
        end else if (buf_en) begin
            wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == WAIT_VALID) && (wd_q != '0)) begin
            wd_q <= wd_q - WD_W'(1);
        end
    end

    // run_q saturates above LATENCY so overly long bursts still flag an error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            burst_q <= '0;
            run_q   <= '0;
        end else if (state_q == WAIT_VALID) begin
            burst_q <= '0;
            run_q   <= RL_W'(1);
        end else if (state_q == STREAM) begin
            if (fall) burst_q <= burst_q + BC_W'(1);
            if (buf_data_valid) begin
                if (!valid_q) begin
                    run_q <= RL_W'(1);
                end else if (run_q != RL_MAX) begin
                    run_q <= run_q + RL_W'(1);
                end
            end
        end
    end

    tile_addr_gen #(
        .IPN        (INPUT_PARALLEL_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_WIDTH (BASE_WIDTH),
        .ROW_PITCH  (ROW_PITCH)
    ) u_addr_gen (
        .clk        (clk),
        .nrst       (nrst),
        .load       (accept),
        .load_base  (cmd_base),
        .advance    (advance),
        .stride     (stride_q),
        .buf_addr_i (buf_addr_i),
        .mem_addr_o (mem_addr_o)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tile_idx    = tile_idx_q;
    assign job_done    = job_end || zero_done_q;
    assign err_timeout = err_timeout_q;
    assign err_burst   = err_burst_q;

endmodule
